// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, default timing and auto-repeat constants for keypad_scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;
  localparam int DEFAULT_SCAN_DIV = 5000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 8;
  localparam int REPEAT_FIRST = 16;
  localparam int REPEAT_NEXT = 4;
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for the keypad rows; resets to all ones (rows idle high).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clock or posedge reset)
    if (reset) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with tick-based press/release debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);
  state_t state, state_nx;
  logic [DW-1:0] div;
  logic [3:0] row_s, match_cnt, cnt_nx, code_nx;
  logic [1:0] col_idx, col_nx, cand_row, cand_nx;
  logic tick, valid_nx, held_nx;
`ifdef KEYPAD_REPEAT_EN
  logic [4:0] rep_cnt, rep_nx;
`endif
  sync_2ff #(.WIDTH(4)) u_sync (.clock(clock), .reset(reset), .d(row_n), .q(row_s));
  assign tick  = div == DW'(SCAN_DIV - 1);
  assign col_n = ~(4'b0001 << col_idx);
  always_comb begin
    state_nx = state;
    col_nx   = col_idx;
    cnt_nx   = match_cnt;
    cand_nx  = cand_row;
    code_nx  = key_code;
    valid_nx = 1'b0;
    held_nx  = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_nx   = rep_cnt;
`endif
    if (tick)
      case (state)
        SCAN:
          if (!(&row_s)) begin
            cand_nx  = lowest_low(row_s);
            cnt_nx   = 4'd1;
            state_nx = CONFIRM;
          end else col_nx = col_idx + 2'd1;
        CONFIRM:
          if (!row_s[cand_row]) begin
            cnt_nx = match_cnt + 4'd1;
            if (cnt_nx == DT) begin
              code_nx  = {cand_row, col_idx};
              valid_nx = 1'b1;
              held_nx  = 1'b1;
              cnt_nx   = 4'd0;
              state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_nx   = 5'd0;
`endif
            end
          end else begin
            cnt_nx   = 4'd0;
            col_nx   = col_idx + 2'd1;
            state_nx = SCAN;
          end
        HELD: begin
          // match_cnt now counts consecutive released ticks of the accepted row
          cnt_nx = row_s[cand_row] ? match_cnt + 4'd1 : 4'd0;
          if (cnt_nx == DT) begin
            held_nx  = 1'b0;
            cnt_nx   = 4'd0;
            col_nx   = col_idx + 2'd1;
            state_nx = SCAN;
          end
`ifdef KEYPAD_REPEAT_EN
          rep_nx = rep_cnt + 5'd1;
          if (rep_nx == 5'(REPEAT_FIRST)) begin
            valid_nx = held_nx;
            rep_nx   = 5'(REPEAT_FIRST - REPEAT_NEXT);
          end
`endif
        end
        default: state_nx = SCAN;
      endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= SCAN;
      div       <= '0;
      col_idx   <= 2'd0;
      match_cnt <= 4'd0;
      cand_row  <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= 5'd0;
`endif
    end else begin
      state     <= state_nx;
      div       <= tick ? '0 : div + DW'(1);
      col_idx   <= col_nx;
      match_cnt <= cnt_nx;
      cand_row  <= cand_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_nx;
`endif
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench; a keypad matrix model answers the column strobe.
module tb_keypad_scanner;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] row_n, col_n, key_code;
  logic key_valid, key_held;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [3:0] code; int gap;} exp_t;
  exp_t sb[$];
  logic direct = 1'b1;
  logic [3:0] row_dir = 4'hF;
  logic kon[4];
  logic [1:0] kr[4], kc[4];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clock(clock), .reset(reset), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // a pressed key shorts its row to its column strobe
  always_comb begin
    row_n = direct ? row_dir : 4'hF;
    for (int i = 0; i < 4; i++)
      if (!direct && kon[i] && !col_n[kc[i]]) row_n[kr[i]] = 1'b0;
  end

  int last_cyc = 0;
  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    if (key_valid) begin
      exp_t e;
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_consecutive: key_valid high on two cycles at cyc %0d", cyc);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: key_code=%0d at cyc %0d, none expected", key_code, cyc);
      end else begin
        e = sb.pop_front();
        if (key_code !== e.code || (e.gap >= 0 && cyc - last_cyc != e.gap)) begin
          errors++;
          $display("FAIL key_event: code=%0d gap=%0d, expected code=%0d gap=%0d",
                   key_code, cyc - last_cyc, e.code, e.gap);
        end
      end
      last_cyc = cyc;
    end
    prev_valid = key_valid;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic wait_held(input logic v, input string nm);
    int n = 0;
    while (key_held !== v && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (key_held !== v) begin
      errors++;
      $display("FAIL %s: key_held=%b, expected %b within 400 cycles", nm, key_held, v);
    end
  endtask

  task automatic wait_col_change(input string nm);
    logic [3:0] c0 = col_n;
    int n = 0;
    while (col_n === c0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (col_n === c0) begin
      errors++;
      $display("FAIL %s: col_n stuck at %b, expected it to advance", nm, col_n);
    end
  endtask

  task automatic push(input logic [3:0] code, input int gap);
    exp_t e;
    e.code = code;
    e.gap = gap;
    sb.push_back(e);
  endtask

  initial begin
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin kon[i] = 1'b0; kr[i] = 2'd0; kc[i] = 2'd0; end
    // reset state
    repeat (3) @(negedge clock);
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_key_code", key_code, 4'd0);
    chk("rst_key_valid", {3'b0, key_valid}, 4'd0);
    chk("rst_key_held", {3'b0, key_held}, 4'd0);
    reset = 1'b0;
    // idle scan: column advances every 4 cycles
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      e = ~(4'b0001 << ((k / 4) % 4));
      chk("idle_col_n", col_n, e);
    end
    // press row 2 col 1
    direct = 1'b0;
    push(4'd9, -1);
    kr[0] = 2'd2; kc[0] = 2'd1; kon[0] = 1'b1;
    wait_held(1'b1, "press_9_held");
    chk("press_9_code", key_code, 4'd9);
    chk("press_9_col", col_n, 4'b1101);
    repeat (40) @(negedge clock);
    chk("held_9_col", col_n, 4'b1101);
    chk("held_9_held", {3'b0, key_held}, 4'd1);
    kon[0] = 1'b0;
    wait_held(1'b0, "release_9");
    chk("release_9_col", col_n, 4'b1011);
    chk("release_9_code", key_code, 4'd9);
    // bounce: one tick low, one tick high, five times
    direct = 1'b1;
    row_dir = 4'hF;
    wait_col_change("bounce_align");
    for (int i = 0; i < 5; i++) begin
      row_dir = 4'b1110;
      repeat (4) @(negedge clock);
      row_dir = 4'hF;
      repeat (4) @(negedge clock);
    end
    chk("bounce_held", {3'b0, key_held}, 4'd0);
    wait_col_change("bounce_resume");
    // reset at the second CONFIRM tick
    wait_col_change("rstc_align");
    row_dir = 4'b1110;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rstc_col", col_n, 4'b1110);
    chk("rstc_code", key_code, 4'd0);
    chk("rstc_held", {3'b0, key_held}, 4'd0);
    chk("rstc_valid", {3'b0, key_valid}, 4'd0);
    row_dir = 4'hF;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("rstc_after_held", {3'b0, key_held}, 4'd0);
    // reset in HELD after accepting row 1 col 2
    direct = 1'b0;
    push(4'd6, -1);
    kr[0] = 2'd1; kc[0] = 2'd2; kon[0] = 1'b1;
    wait_held(1'b1, "press_6_held");
    chk("press_6_code", key_code, 4'd6);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rsth_code", key_code, 4'd0);
    chk("rsth_held", {3'b0, key_held}, 4'd0);
    chk("rsth_col", col_n, 4'b1110);
    kon[0] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("rsth_after_held", {3'b0, key_held}, 4'd0);
    // two rows in one column: lowest row wins
    push(4'd5, -1);
    kr[0] = 2'd3; kc[0] = 2'd1; kon[0] = 1'b1;
    kr[1] = 2'd1; kc[1] = 2'd1; kon[1] = 1'b1;
    wait_held(1'b1, "press_5_held");
    chk("press_5_code", key_code, 4'd5);
    kon[0] = 1'b0; kon[1] = 1'b0;
    wait_held(1'b0, "release_5");
    // long hold of row 3 col 3 with other keys pressed meanwhile
    push(4'd15, -1);
`ifdef KEYPAD_REPEAT_EN
    push(4'd15, 64);
    for (int i = 0; i < 3; i++) push(4'd15, 16);
`endif
    kr[0] = 2'd3; kc[0] = 2'd3; kon[0] = 1'b1;
    wait_held(1'b1, "press_15_held");
    repeat (4) @(negedge clock);
    kr[1] = 2'd0; kc[1] = 2'd0; kon[1] = 1'b1;
    kr[2] = 2'd0; kc[2] = 2'd3; kon[2] = 1'b1;
    repeat (32) @(negedge clock);
    chk("held_15_col", col_n, 4'b0111);
    chk("held_15_code", key_code, 4'd15);
    kon[1] = 1'b0; kon[2] = 1'b0;
    repeat (76) @(negedge clock);
    kon[0] = 1'b0;
    wait_held(1'b0, "release_15");
    chk("release_15_col", col_n, 4'b1110);
    repeat (20) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected key_valid pulses never seen", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
